// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. Merges pipeline write-back, a multi-cycle
// unit, a debug port and a clear sweep onto one registered write port.
// Write-back always wins. mc and dbg share round-robin priority. The sweep
// writes CLEAR_VALUE to registers 1..31 and skips any register that
// write-back has already written during the same sweep.
module rf_write_arbiter #(
    parameter logic [31:0] CLEAR_VALUE = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    input  logic        clr_start,
    output logic        clr_busy,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:1] dirty;
    logic        rr_dbg;     // 0: mc owns a tie, 1: dbg owns a tie

    logic        idle_arb;
    logic        sweep_step;
    logic        sweep_skip;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    // Grants for mc/dbg: only in IDLE, only when write-back is quiet
    always_comb begin
        idle_arb  = (state == IDLE) && !wb_we && !reset;
        mc_ready  = idle_arb && mc_valid  && (!dbg_valid || !rr_dbg);
        dbg_ready = idle_arb && dbg_valid && (!mc_valid  ||  rr_dbg);
    end

    // Sweep step and whether the current sweep address was already written by WB
    always_comb begin
        sweep_step = (state == CLEAR) && !wb_we;
        sweep_skip = 1'b0;
        for (int i = 1; i < 32; i++)
            if (cnt == i[4:0]) sweep_skip = dirty[i];
    end

    // Select the write that reaches the port this cycle
    always_comb begin
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        if (wb_we) begin
            w_en   = 1'b1;
            w_addr = wb_addr;
            w_data = wb_data;
        end else if (sweep_step) begin
            w_en   = !sweep_skip;
            w_addr = cnt;
            w_data = CLEAR_VALUE;
        end else if (mc_ready) begin
            w_en   = 1'b1;
            w_addr = mc_addr;
            w_data = mc_data;
        end else if (dbg_ready) begin
            w_en   = 1'b1;
            w_addr = dbg_addr;
            w_data = dbg_data;
        end
    end

    // Registered write port, round-robin pointer and sweep FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            clr_busy <= 1'b0;
            cnt      <= 5'd1;
            dirty    <= '0;
            rr_dbg   <= 1'b0;
        end else begin
            // Address 0 is consumed but never written
            rf_we <= w_en && (w_addr != 5'd0);
            if (w_en) begin
                rf_addr <= w_addr;
                rf_data <= w_data;
            end
            if (mc_ready || dbg_ready)
                rr_dbg <= mc_ready;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        cnt      <= 5'd1;
                        dirty    <= '0;
                    end
                end
                CLEAR: begin
                    if (wb_we) begin
                        for (int i = 1; i < 32; i++)
                            if (wb_addr == i[4:0]) dirty[i] <= 1'b1;
                    end
                    if (sweep_step) begin
                        if (cnt == 5'd31) begin
                            state    <= IDLE;
                            clr_busy <= 1'b0;
                            cnt      <= 5'd1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, contention, round-robin,
// address-0 handling, full sweep, dirty-mask skipping and mid-sweep reset.
module tb_rf_write_arbiter;

    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_addr;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ready;
    logic        clr_start;
    logic        clr_busy;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.CLEAR_VALUE(CV)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        mc_valid = 0; mc_addr = 0; mc_data = 0;
        dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
        clr_start = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        mc_valid = 1; mc_addr = 5'd3; dbg_valid = 1; dbg_addr = 5'd4;
        step();
        n_checks++; if (rf_we !== 1'b0)   begin n_fail++; $display("FAIL reset_rf_we got %0b exp 0", rf_we); end
        n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr got %0d exp 0", rf_addr); end
        n_checks++; if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_data got %h exp 0", rf_data); end
        n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy got %0b exp 0", clr_busy); end
        n_checks++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mc_ready got %0b exp 0", mc_ready); end
        n_checks++; if (dbg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_ready got %0b exp 0", dbg_ready); end
        idle_inputs();
        reset = 0;
        step();
    endtask

    task automatic test_contention();
        do_reset();
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'hAAAA0000;
        mc_valid = 1; mc_addr = 5'd6; mc_data = 32'h00006666;
        #1;
        n_checks++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL cont_mc_ready_blocked got %0b exp 0", mc_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hAAAA0000)
            begin n_fail++; $display("FAIL cont_wb_write got we=%0b addr=%0d data=%h exp 1/5/aaaa0000", rf_we, rf_addr, rf_data); end
        wb_we = 0;
        #1;
        n_checks++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL cont_mc_ready got %0b exp 1", mc_ready); end
        @(posedge clk); #1;
        mc_valid = 0;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd6 || rf_data !== 32'h00006666)
            begin n_fail++; $display("FAIL cont_mc_write got we=%0b addr=%0d data=%h exp 1/6/00006666", rf_we, rf_addr, rf_data); end
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL cont_single_pulse got %0b exp 0", rf_we); end
    endtask

    task automatic test_round_robin();
        logic exp_mc;
        do_reset();
        mc_valid = 1; mc_addr = 5'd7; mc_data = 32'h77;
        dbg_valid = 1; dbg_addr = 5'd8; dbg_data = 32'h88;
        exp_mc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (mc_ready !== exp_mc || dbg_ready !== !exp_mc)
                begin n_fail++; $display("FAIL rr_grant%0d got mc=%0b dbg=%0b exp mc=%0b", i, mc_ready, dbg_ready, exp_mc); end
            @(posedge clk); #1;
            n_checks++; if (rf_we !== 1'b1 || rf_addr !== (exp_mc ? 5'd7 : 5'd8))
                begin n_fail++; $display("FAIL rr_write%0d got we=%0b addr=%0d exp mc=%0b", i, rf_we, rf_addr, exp_mc); end
            exp_mc = !exp_mc;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_addr0();
        do_reset();
        dbg_valid = 1; dbg_addr = 5'd0; dbg_data = 32'h12345678;
        #1;
        n_checks++; if (dbg_ready !== 1'b1) begin n_fail++; $display("FAIL a0_dbg_ready got %0b exp 1", dbg_ready); end
        @(posedge clk); #1;
        dbg_valid = 0;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL a0_rf_we got %0b exp 0", rf_we); end
    endtask

    task automatic test_full_sweep();
        int busy_cycles;
        do_reset();
        clr_start = 1;
        step();
        clr_start = 0;
        mc_valid = 1; mc_addr = 5'd9; mc_data = 32'h99;
        busy_cycles = 0;
        for (int a = 1; a <= 31; a++) begin
            #1;
            if (clr_busy === 1'b1) busy_cycles++;
            n_checks++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL sweep_mc_ready at %0d got %0b exp 0", a, mc_ready); end
            @(posedge clk); #1;
            if (a == 31) mc_valid = 0;
            n_checks++; if (rf_we !== 1'b1 || rf_addr !== a[4:0] || rf_data !== CV)
                begin n_fail++; $display("FAIL sweep_write got we=%0b addr=%0d data=%h exp 1/%0d/%h", rf_we, rf_addr, rf_data, a, CV); end
        end
        n_checks++; if (busy_cycles != 31) begin n_fail++; $display("FAIL sweep_busy_len got %0d exp 31", busy_cycles); end
        n_checks++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_done got %0b exp 0", clr_busy); end
        idle_inputs();
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL sweep_quiet got %0b exp 0", rf_we); end
    endtask

    task automatic test_dirty_mask();
        int exp_addr;
        int n_sweep;
        bit done;
        do_reset();
        clr_start = 1;
        step();
        clr_start = 0;
        step();
        step();
        n_sweep = 2;
        wb_we = 1; wb_addr = 5'd20; wb_data = 32'h1234;
        step();
        wb_we = 0;
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd20 || rf_data !== 32'h1234)
            begin n_fail++; $display("FAIL dirty_wb_write got we=%0b addr=%0d data=%h exp 1/20/1234", rf_we, rf_addr, rf_data); end
        exp_addr = 3;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (rf_we === 1'b1) begin
                n_sweep++;
                n_checks++; if (rf_addr !== exp_addr[4:0] || rf_data !== CV)
                    begin n_fail++; $display("FAIL dirty_seq got addr=%0d data=%h exp %0d/%h", rf_addr, rf_data, exp_addr, CV); end
                exp_addr++;
                if (exp_addr == 20) exp_addr = 21;
            end
            if (clr_busy === 1'b0) done = 1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL dirty_timeout got busy=%0b exp 0", clr_busy); end
        n_checks++; if (n_sweep != 30) begin n_fail++; $display("FAIL dirty_count got %0d exp 30", n_sweep); end
        n_checks++; if (exp_addr != 32) begin n_fail++; $display("FAIL dirty_last got next=%0d exp 32", exp_addr); end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < 9; i++) step();
        n_checks++; if (rf_addr !== 5'd9 || clr_busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_pre got addr=%0d busy=%0b exp 9/1", rf_addr, clr_busy); end
        reset = 1;
        step();
        n_checks++; if (rf_we !== 1'b0 || clr_busy !== 1'b0)
            begin n_fail++; $display("FAIL mid_abort got we=%0b busy=%0b exp 0/0", rf_we, clr_busy); end
        reset = 0;
        step();
        step();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse got %0b exp 0", rf_we); end
        clr_start = 1;
        step();
        clr_start = 0;
        step();
        n_checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd1 || clr_busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_restart got we=%0b addr=%0d busy=%0b exp 1/1/1", rf_we, rf_addr, clr_busy); end
        step();
        n_checks++; if (rf_addr !== 5'd2) begin n_fail++; $display("FAIL mid_restart2 got %0d exp 2", rf_addr); end
    endtask

    task automatic test_clr_start_ignored();
        do_reset();
        clr_start = 1;
        step();
        for (int i = 0; i < 4; i++) step();
        clr_start = 0;
        n_checks++; if (rf_addr !== 5'd4) begin n_fail++; $display("FAIL restart_ignored got %0d exp 4", rf_addr); end
        step();
        n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL restart_ignored2 got %0d exp 5", rf_addr); end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_contention();
        test_round_robin();
        test_addr0();
        test_full_sweep();
        test_dirty_mask();
        test_reset_mid_sweep();
        test_clr_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
